// File: rtl/nn_layer_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
// Contents: FSM state encoding, register offsets, CTRL bit positions and
// the width of the neuron index / ARGMAX register.
package nn_layer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_NIN_LO = 3'd1;
    localparam logic [2:0] REG_NIN_HI = 3'd2;
    localparam logic [2:0] REG_NOUT   = 3'd3;
    localparam logic [2:0] REG_ARGMAX = 3'd4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // N_OUT is an 8-bit register, so neuron indices fit in 8 bits.
    localparam int IDX_W = 8;

endpackage

// File: rtl/nn_layer_seq_argmax_tracker.sv
// Running argmax over the accumulators of one layer.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   load          first neuron: take value/index unconditionally
//   update        later neuron: take value/index only if value > best (signed)
//   value         signed accumulator of the current neuron
//   index         index of the current neuron
//   idx_nxt       winning index including the current neuron (combinational),
//                 so the caller can latch the final result in the same cycle
module argmax_tracker #(
    parameter int ACC_W = 32,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    update,
    input  logic signed [ACC_W-1:0] value,
    input  logic        [IDX_W-1:0] index,
    output logic        [IDX_W-1:0] idx_nxt
);

    logic signed [ACC_W-1:0] best;
    logic        [IDX_W-1:0] idx;
    logic                    take;

    // Strict compare: a tie keeps the earlier (lower) index.
    assign take    = load | (update & (value > best));
    assign idx_nxt = take ? index : idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best <= '0;
            idx  <= '0;
        end else if (take) begin
            best <= value;
            idx  <= index;
        end
    end

endmodule

// File: rtl/nn_layer_seq.sv
// Sequencer for one fully-connected layer: walks the input and weight BRAMs,
// drives the external MAC, writes one accumulator per output neuron into the
// result BRAM and keeps the index of the largest accumulator.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   address/chipselect/read/
//   write/writedata/readdata     8-bit Avalon-MM slave (readdata registered)
//   mem_en, in_addr, w_addr      input/weight BRAM read port
//   mac_clr, mac_en              MAC control, aligned with BRAM read data
//   acc_in                       signed accumulator from the MAC
//   res_we, res_addr             result BRAM write port (data is acc_in)
//   irq                          done & irq_en
module nn_layer_seq
    import nn_layer_seq_pkg::*;
#(
    parameter int IN_AW   = 13,
    parameter int W_AW    = 19,
    parameter int RES_AW  = 13,
    parameter int ACC_W   = 32,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [7:0]              writedata,
    output logic [7:0]              readdata,
    output logic                    mem_en,
    output logic [IN_AW-1:0]        in_addr,
    output logic [W_AW-1:0]         w_addr,
    output logic                    mac_clr,
    output logic                    mac_en,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    res_we,
    output logic [RES_AW-1:0]       res_addr,
    output logic                    irq
);

    localparam logic [7:0] DRAIN_LAST = 8'(RD_LAT + MAC_LAT - 1);

    state_t              state, state_nxt;
    logic [IN_AW-1:0]    nin, i, nin_m1;
    logic [7:0]          nout, j, argmax, drain_cnt;
    logic [W_AW-1:0]     w_base;
    logic                irq_en, done, busy;
    logic [RD_LAT-1:0]   mac_en_p, mac_clr_p;
    logic [IDX_W-1:0]    best_idx_nxt;
    logic                wr, rd, start_req, zero_len, last_i, last_j;

    assign wr        = chipselect & write;
    assign rd        = chipselect & read & ~write;
    assign start_req = wr && (address == REG_CTRL) && writedata[CTRL_START];
    assign zero_len  = (nin == '0) || (nout == '0);
    assign nin_m1    = nin - 1'b1;
    assign last_i    = (i == nin_m1);
    assign last_j    = (j == nout - 8'd1);
    assign busy      = (state != ST_IDLE);

    assign mem_en   = (state == ST_RUN);
    assign in_addr  = i;
    assign w_addr   = w_base + W_AW'(i);
    assign res_we   = (state == ST_WRITE);
    assign res_addr = RES_AW'(j);
    assign mac_en   = mac_en_p[RD_LAT-1];
    assign mac_clr  = mac_clr_p[RD_LAT-1];
    assign irq      = done & irq_en;

    argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (res_we && (j == 8'd0)),
        .update  (res_we && (j != 8'd0)),
        .value   (acc_in),
        .index   (j),
        .idx_nxt (best_idx_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_req && !zero_len) state_nxt = ST_RUN;
            ST_RUN:   if (last_i) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_j ? ST_IDLE : ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nin       <= '0;
            nout      <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            argmax    <= '0;
            readdata  <= '0;
            i         <= '0;
            j         <= '0;
            w_base    <= '0;
            drain_cnt <= '0;
            mac_en_p  <= '0;
            mac_clr_p <= '0;
        end else begin
            // Delay line lining MAC control up with BRAM read data.
            mac_en_p  <= (mac_en_p << 1) | RD_LAT'(mem_en);
            mac_clr_p <= (mac_clr_p << 1) | RD_LAT'(mem_en && (i == '0));

            // clr_done first so that a start in the same write overrides it below.
            if (wr && (address == REG_CTRL)) begin
                irq_en <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_CLR_DONE]) done <= 1'b0;
            end

            if (wr && !busy) begin
                case (address)
                    REG_NIN_LO: nin[7:0]       <= writedata;
                    REG_NIN_HI: nin[IN_AW-1:8] <= writedata[IN_AW-9:0];
                    REG_NOUT:   nout           <= writedata;
                    default: ;
                endcase
            end

            if (rd) begin
                case (address)
                    REG_CTRL:   readdata <= {5'b0, irq_en, done, busy};
                    REG_NIN_LO: readdata <= nin[7:0];
                    REG_NIN_HI: readdata <= 8'(nin[IN_AW-1:8]);
                    REG_NOUT:   readdata <= nout;
                    REG_ARGMAX: readdata <= argmax;
                    default:    readdata <= '0;
                endcase
            end else begin
                readdata <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (zero_len) begin
                            done   <= 1'b1;
                            argmax <= '0;
                        end else begin
                            done   <= 1'b0;
                            i      <= '0;
                            j      <= '0;
                            w_base <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    drain_cnt <= '0;
                    if (!last_i) i <= i + 1'b1;
                end
                ST_DRAIN: drain_cnt <= drain_cnt + 8'd1;
                ST_WRITE: begin
                    i <= '0;
                    if (last_j) begin
                        done   <= 1'b1;
                        argmax <= best_idx_nxt;
                    end else begin
                        j      <= j + 8'd1;
                        w_base <= w_base + W_AW'(nin);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Self-checking bench for nn_layer_seq with behavioural BRAM/MAC models and a
// dot-product / argmax reference computed directly from the memory contents.
module tb_nn_layer_seq;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [2:0]         address = '0;
    logic               chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [7:0]         writedata = '0;
    logic [7:0]         readdata;
    logic               mem_en, mac_clr, mac_en, res_we, irq;
    logic [12:0]        in_addr, res_addr;
    logic [18:0]        w_addr;
    logic signed [31:0] acc_in = '0;

    nn_layer_seq dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .mem_en(mem_en), .in_addr(in_addr), .w_addr(w_addr), .mac_clr(mac_clr),
        .mac_en(mac_en), .acc_in(acc_in), .res_we(res_we), .res_addr(res_addr),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Environment: 1-cycle BRAMs and a MAC with one cycle of latency.
    int in_mem[64];
    int w_mem[1024];
    int in_q = 0, w_q = 0;

    always @(posedge clk) if (mem_en) begin
        in_q <= in_mem[in_addr[5:0]];
        w_q  <= w_mem[w_addr[9:0]];
    end

    always @(posedge clk) if (mac_en) acc_in <= (mac_clr ? 32'sd0 : acc_in) + in_q * w_q;

    // Monitor
    int mon_in[$], mon_w[$], mon_ra[$], mon_rv[$];
    int cyc = 0, first_mem_cyc = 0, last_we_cyc = 0, clr_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_en) begin
            if (mon_in.size() == 0) first_mem_cyc = cyc;
            mon_in.push_back(int'(in_addr));
            mon_w.push_back(int'(w_addr));
        end
        if (mac_en && mac_clr) clr_cnt++;
        if (res_we) begin
            mon_ra.push_back(int'(res_addr));
            mon_rv.push_back(int'(acc_in));
            last_we_cyc = cyc;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_in.delete(); mon_w.delete(); mon_ra.delete(); mon_rv.delete();
        clr_cnt = 0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic start_layer(input int nin, input int nout, input logic [7:0] ctrl);
        bus_write(3'd1, 8'(nin & 255));
        bus_write(3'd2, 8'(nin >> 8));
        bus_write(3'd3, 8'(nout));
        clear_mon();
        bus_write(3'd0, ctrl | 8'h01);
    endtask

    task automatic wait_idle(output logic [7:0] st);
        bit ok = 1'b0;
        st = '0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            bus_read(3'd0, st);
            if (!st[0]) ok = 1'b1;
        end
        if (!ok) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic fill_rand(input int nin, input int nout);
        for (int k = 0; k < nin; k++) in_mem[k] = int'($urandom_range(0, 6)) - 3;
        for (int k = 0; k < nin * nout; k++) w_mem[k] = int'($urandom_range(0, 6)) - 3;
    endtask

    // Reference: y[j] = sum_i x[i] * W[j*nin + i]; argmax = first index holding the maximum.
    task automatic check_layer(input int nin, input int nout, input string tag);
        int exp_v[$];
        int mx, best, bad, n;
        logic [7:0] rd_v;
        for (int jj = 0; jj < nout; jj++) begin
            int s = 0;
            for (int ii = 0; ii < nin; ii++) s += in_mem[ii] * w_mem[jj * nin + ii];
            exp_v.push_back(s);
        end
        mx = exp_v[0];
        foreach (exp_v[k]) if (exp_v[k] > mx) mx = exp_v[k];
        best = -1;
        foreach (exp_v[k]) if (best < 0 && exp_v[k] == mx) best = k;

        chk({tag, "_nres"}, mon_rv.size(), nout);
        n = (mon_rv.size() < nout) ? mon_rv.size() : nout;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_res_addr"}, mon_ra[k], k);
            chk({tag, "_res_val"}, mon_rv[k], exp_v[k]);
        end
        chk({tag, "_nmem"}, mon_in.size(), nin * nout);
        bad = 0;
        for (int k = 0; k < mon_in.size() && k < nin * nout; k++)
            if (mon_in[k] != k % nin || mon_w[k] != k) bad++;
        chk({tag, "_addr_seq"}, bad, 0);
        chk({tag, "_nclr"}, clr_cnt, nout);
        bus_read(3'd4, rd_v);
        chk({tag, "_argmax"}, rd_v, best);
    endtask

    logic [7:0] st, rv;
    int nin_r, nout_r;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs", {mem_en, mac_en, mac_clr, res_we, irq}, 5'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_readdata", readdata, 8'h00);
        bus_read(3'd0, st);
        chk("rst_status", st, 8'h00);
        bus_read(3'd4, rv);
        chk("rst_argmax", rv, 8'h00);

        // Directed 3x2 layer
        fill_rand(3, 2);
        start_layer(3, 2, 8'h00);
        wait_idle(st);
        check_layer(3, 2, "l3x2");
        chk("l3x2_busy_span", last_we_cyc - first_mem_cyc + 1, 12);
        chk("l3x2_status", st, 8'h02);

        // Argmax with a tie and with all-negative accumulators
        in_mem[0] = 1;
        w_mem[0] = -5; w_mem[1] = 7; w_mem[2] = 7; w_mem[3] = -1;
        start_layer(1, 4, 8'h00);
        wait_idle(st);
        check_layer(1, 4, "tie");
        w_mem[0] = -9; w_mem[1] = -3; w_mem[2] = -4; w_mem[3] = -8;
        start_layer(1, 4, 8'h00);
        wait_idle(st);
        check_layer(1, 4, "neg");

        // Zero-length layer: immediate done, no traffic, ARGMAX cleared
        start_layer(0, 2, 8'h00);
        bus_read(3'd0, st);
        chk("zero_status", st, 8'h02);
        repeat (10) @(negedge clk);
        chk("zero_nmem", mon_in.size(), 0);
        chk("zero_nres", mon_rv.size(), 0);
        bus_read(3'd4, rv);
        chk("zero_argmax", rv, 8'h00);

        // Writes and start during busy are ignored; irq follows done
        fill_rand(4, 3);
        start_layer(4, 3, 8'h04);
        bus_read(3'd0, st);
        chk("busy_status", st, 8'h05);
        bus_write(3'd3, 8'd9);
        bus_write(3'd0, 8'h05);
        chk("busy_irq_low", irq, 1'b0);
        wait_idle(st);
        chk("busy_done_status", st, 8'h06);
        chk("irq_high", irq, 1'b1);
        bus_read(3'd3, rv);
        chk("nout_kept", rv, 8'd3);
        check_layer(4, 3, "busyw");
        bus_write(3'd0, 8'h06);
        chk("irq_cleared", irq, 1'b0);
        bus_read(3'd0, st);
        chk("clr_status", st, 8'h04);

        // Reset in the middle of RUN
        fill_rand(5, 3);
        start_layer(5, 3, 8'h04);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {mem_en, mac_en, mac_clr, res_we, irq}, 5'd0);
        chk("mid_rst_addr", {in_addr, w_addr, res_addr}, 45'd0);
        chk("mid_rst_rd", readdata, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd0, st);
        chk("post_rst_status", st, 8'h00);
        bus_read(3'd3, rv);
        chk("post_rst_nout", rv, 8'h00);
        fill_rand(3, 3);
        start_layer(3, 3, 8'h00);
        wait_idle(st);
        check_layer(3, 3, "post_rst");

        // Register map odds and ends
        bus_write(3'd1, 8'hFF);
        bus_write(3'd2, 8'h1F);
        bus_read(3'd1, rv);
        chk("nin_lo", rv, 8'hFF);
        bus_read(3'd2, rv);
        chk("nin_hi", rv, 8'h1F);
        bus_write(3'd5, 8'hAA);
        bus_read(3'd5, rv);
        chk("reg5", rv, 8'h00);
        @(negedge clk);
        chk("idle_readdata", readdata, 8'h00);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd3; writedata = 8'd7;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        chk("wr_prio_rd", readdata, 8'h00);
        bus_read(3'd3, rv);
        chk("wr_prio_val", rv, 8'd7);

        // Randomized layers
        for (int t = 0; t < 8; t++) begin
            nin_r  = int'($urandom_range(1, 8));
            nout_r = int'($urandom_range(1, 8));
            fill_rand(nin_r, nout_r);
            start_layer(nin_r, nout_r, 8'h00);
            wait_idle(st);
            check_layer(nin_r, nout_r, "rand");
            chk("rand_status", st, 8'h02);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
